fifo_rr_write_arbiter: RTL and testbench
========================================

Name: fifo_rr_write_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port among NUM_REQ independent producers.
- Grants one producer at a time for a burst of up to BURST_LEN words.
- Drives the FIFO's wr_en/data_in and watches its full/wr_ack/overflow outputs, reporting protocol errors as sticky flags.
- Sits directly in front of the FIFO write side, on the same clock.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- FIFO_WIDTH, 16, data word width; equals the FIFO's data width.
- BURST_LEN, 4, max words per grant (1..16).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-producer word-valid.
- req_data  input  NUM_REQ*FIFO_WIDTH  producer i word at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept; a word transfers when valid & ready.
- grant  output  NUM_REQ  one-hot current owner, all-zero when idle.
- wr_en  output  1  FIFO write enable.
- data_in  output  FIFO_WIDTH  FIFO write data.
- full  input  1  FIFO full.
- wr_ack  input  1  FIFO write acknowledge, registered, one cycle after wr_en.
- overflow  input  1  FIFO overflow, registered, one cycle after wr_en.
- ovf_err  output  1  sticky: overflow seen.
- ack_err  output  1  sticky: wr_en not followed by wr_ack or overflow.
- words_written  output  16  count of acked writes, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, grant=0, burst count=0, last_owner=NUM_REQ-1 (so requester 0 has first priority).
  - ovf_err=0, ack_err=0, words_written=0.
  - wr_en=0 and req_ready=0 during and after reset until a grant exists.
  - rst mid-burst aborts the burst; no partial state survives.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid and !full, pick the first valid index scanning from last_owner+1 upward, modulo NUM_REQ.
  - Register grant (one-hot) and clear burst count; go to BURST next cycle.
  - Arbitration costs exactly 1 cycle; no writes occur in IDLE.
- BURST (owner g):
  - wr_en = req_valid[g] & !full (combinational).
  - req_ready[g] = wr_en; all other req_ready=0.
  - data_in = req_data slice g, valid whenever wr_en=1; otherwise it holds slice g.
  - On a transfer, burst count increments.
  - Exit to IDLE (grant=0, last_owner=g) at the clock edge where either:
    - a transfer occurs with count==BURST_LEN-1, or
    - req_valid[g]=0.
  - full=1 with req_valid[g]=1: stay in BURST, count held, wr_en=0 (stall, no preemption).
  - After exit, IDLE re-arbitrates next cycle; an idle cycle between grants is required.
- Back-to-back writes within a burst: one word per cycle while full=0.
- Response tracking: register wr_en as wr_en_d.
  - wr_en_d & wr_ack → words_written+1.
  - wr_en_d & overflow → ovf_err=1.
  - wr_en_d & !wr_ack & !overflow → ack_err=1.
  - wr_ack or overflow without wr_en_d → ack_err=1.
  - Sticky flags clear only on rst.
- Fairness: a continuously valid producer waits at most (NUM_REQ-1) bursts plus one arbitration cycle per burst, excluding full stalls.
- Ports of non-owners are ignored; their req_valid may toggle freely.

Test Plan:
- Only req0 valid with 6 words, BURST_LEN=4 → grant=0001 one cycle after valid; 4 consecutive wr_en; 1 idle cycle; grant=0001 again; 2 wr_en; words_written=6 after the final ack.
- All 4 producers continuously valid → grant sequence 0001,0010,0100,1000,0001; each burst is 4 writes; data_in matches the owner's slice every write.
- full asserted for 3 cycles after the 2nd word of req2's burst → wr_en=0 and req_ready=0 for those 3 cycles; grant holds; burst resumes and totals exactly 4 words.
- req1 drops valid after 2 words while req3 valid → FSM returns to IDLE; next grant=1000 (req2 skipped, not valid).
- rst pulsed mid-burst of req3 → next cycle grant=0, wr_en=0, counters and flags 0; with all valid, first grant after reset is 0001.
- FIFO model returns overflow instead of wr_ack for one write → ovf_err=1 and stays 1 across further bursts until rst; spurious wr_ack with no prior wr_en → ack_err=1.

Source files
------------

// File: rtl/fifo_rr_write_arbiter_if.sv
// Producer request bus plus FIFO write-side signals shared by the round-robin write arbiter.
// The arbiter drives the master modport; producers and the FIFO sit on the slave modport.
interface fifo_rr_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            grant;
   logic                          wr_en;
   logic [FIFO_WIDTH-1:0]         data_in;
   logic                          full;
   logic                          wr_ack;
   logic                          overflow;

   modport master (
      input  req_valid, req_data, full, wr_ack, overflow,
      output req_ready, grant, wr_en, data_in
   );

   modport slave (
      output req_valid, req_data, full, wr_ack, overflow,
      input  req_ready, grant, wr_en, data_in
   );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write arbiter: one producer owns the FIFO write port for up to BURST_LEN words,
// and the FIFO's registered wr_ack/overflow responses are checked one cycle behind each write.
module fifo_rr_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_LEN  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   fifo_rr_write_arbiter_if.master bus,
   output logic                   ovf_err,
   output logic                   ack_err,
   output logic [15:0]            words_written
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t             state_r, state_n_s;
   logic [NUM_REQ-1:0] grant_r, grant_n_s;
   logic [IDX_W-1:0]   owner_r, owner_n_s;
   logic [IDX_W-1:0]   last_owner_r, last_owner_n_s;
   logic [CNT_W-1:0]   count_r, count_n_s;
   logic [IDX_W-1:0]   cand_s, pick_s;
   logic               pick_found_s;
   logic               wr_en_s;
   logic               wr_en_d_r;
   logic               ovf_err_r, ack_err_r;
   logic [15:0]        words_r;

   // Search for the first valid producer starting just after the previous owner.
   always_comb begin
      cand_s       = {IDX_W{1'b0}};
      pick_s       = {IDX_W{1'b0}};
      pick_found_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s       = IDX_W'((int'(last_owner_r) + k) % NUM_REQ);
         pick_s       = (!pick_found_s && bus.req_valid[cand_s]) ? cand_s : pick_s;
         pick_found_s = pick_found_s | bus.req_valid[cand_s];
      end
   end

   // Write strobe: the owner's word goes out unless the FIFO is full (stall, never preempt).
   always_comb begin
      wr_en_s = 1'b0;
      if (state_r == BURST) begin
         wr_en_s = bus.req_valid[owner_r] & ~bus.full;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   assign bus.wr_en     = wr_en_s;
   assign bus.req_ready = wr_en_s ? grant_r : {NUM_REQ{1'b0}};
   assign bus.grant     = grant_r;
   assign bus.data_in   = bus.req_data[int'(owner_r) * FIFO_WIDTH +: FIFO_WIDTH];

   // Next-state logic for arbitration and burst progress.
   always_comb begin
      state_n_s      = state_r;
      grant_n_s      = grant_r;
      owner_n_s      = owner_r;
      last_owner_n_s = last_owner_r;
      count_n_s      = count_r;
      case (state_r)
         IDLE: begin
            if (pick_found_s && !bus.full) begin
               state_n_s = BURST;
               owner_n_s = pick_s;
               grant_n_s = ONE_HOT0 << pick_s;
               count_n_s = {CNT_W{1'b0}};
            end else begin
               state_n_s = IDLE;
            end
         end
         BURST: begin
            if (!bus.req_valid[owner_r] || (wr_en_s && (count_r == CNT_LAST))) begin
               state_n_s      = IDLE;
               grant_n_s      = {NUM_REQ{1'b0}};
               last_owner_n_s = owner_r;
               count_n_s      = {CNT_W{1'b0}};
            end else if (wr_en_s) begin
               count_n_s = count_r + CNT_ONE;
            end else begin
               count_n_s = count_r;
            end
         end
         default: begin
            state_n_s = IDLE;
            grant_n_s = {NUM_REQ{1'b0}};
            count_n_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Arbiter state register; reset makes producer 0 the first in line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         grant_r      <= {NUM_REQ{1'b0}};
         owner_r      <= {IDX_W{1'b0}};
         last_owner_r <= LAST_RST;
         count_r      <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_n_s;
         grant_r      <= grant_n_s;
         owner_r      <= owner_n_s;
         last_owner_r <= last_owner_n_s;
         count_r      <= count_n_s;
      end
   end

   // Response tracking: every write must see exactly one of wr_ack/overflow next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_d_r <= 1'b0;
         words_r   <= 16'd0;
         ovf_err_r <= 1'b0;
         ack_err_r <= 1'b0;
      end else begin
         wr_en_d_r <= wr_en_s;
         words_r   <= (wr_en_d_r && bus.wr_ack) ? (words_r + 16'd1) : words_r;
         ovf_err_r <= ovf_err_r | (wr_en_d_r & bus.overflow);
         ack_err_r <= ack_err_r | (wr_en_d_r ? (~bus.wr_ack & ~bus.overflow)
                                             : (bus.wr_ack | bus.overflow));
      end
   end

   assign ovf_err       = ovf_err_r;
   assign ack_err       = ack_err_r;
   assign words_written = words_r;
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench for fifo_rr_write_arbiter: a transaction-level model of ownership and
// FIFO responses predicts every output each cycle, plus directed scenario checks.
module tb_fifo_rr_write_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ovf_err, ack_err;
   logic [15:0] words_written;

   fifo_rr_write_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

   fifo_rr_write_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .ovf_err(ovf_err), .ack_err(ack_err), .words_written(words_written)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: owner index (-1 = none), previous owner, words left in the burst, response bookkeeping.
   int          m_owner, m_last, m_left;
   logic [15:0] m_words;
   logic        m_ovf, m_ack, m_wd;
   logic        inj_ovf, inj_drop, inj_spur;
   logic [N-1:0] exp_grant, exp_ready;
   logic         exp_we;
   logic [W-1:0] exp_data;
   logic [42:0]  exp_vec, act_vec;

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic f);
      bus.req_valid = v;
      bus.full      = f;
      bus.req_data  = (N*W)'({$urandom(), $urandom()});
   endtask

   task automatic predict();
      exp_grant = '0; exp_we = 1'b0; exp_ready = '0; exp_data = '0;
      if (m_owner >= 0) begin
         exp_grant = N'(1) << m_owner;
         exp_we    = bus.req_valid[m_owner] && !bus.full;
         exp_ready = exp_we ? exp_grant : '0;
         exp_data  = bus.req_data[m_owner*W +: W];
      end
      exp_vec = {exp_grant, exp_we, exp_ready, exp_data, m_words, m_ovf, m_ack};
   endtask

   task automatic settle();
      predict();
      @(negedge clk);
      act_vec = {bus.grant, bus.wr_en, bus.req_ready, (m_owner >= 0) ? bus.data_in : 16'h0,
                 words_written, ovf_err, ack_err};
   endtask

   task automatic advance();
      logic we, was_rst, r_ack, r_ovf, f;
      logic [N-1:0] v;
      predict();
      we = exp_we; was_rst = rst; r_ack = bus.wr_ack; r_ovf = bus.overflow;
      v = bus.req_valid; f = bus.full;
      @(posedge clk);
      if (was_rst) begin
         m_owner = -1; m_last = N - 1; m_left = 0;
         m_words = 16'd0; m_ovf = 1'b0; m_ack = 1'b0; m_wd = 1'b0;
      end else begin
         if (m_wd && r_ack) m_words = m_words + 16'd1;
         if (m_wd && r_ovf) m_ovf = 1'b1;
         if (m_wd != (r_ack || r_ovf)) m_ack = 1'b1;
         m_wd = we;
         if (m_owner < 0) begin
            if (v != '0 && !f) begin
               m_owner = rr_pick(v, m_last);
               m_left  = BL;
            end
         end else if (!v[m_owner]) begin
            m_last = m_owner; m_owner = -1;
         end else if (we) begin
            m_left--;
            if (m_left == 0) begin m_last = m_owner; m_owner = -1; end
         end
      end
      #1;
      if (was_rst) begin
         bus.wr_ack = 1'b0; bus.overflow = 1'b0;
      end else if (we) begin
         bus.wr_ack = !inj_ovf && !inj_drop; bus.overflow = inj_ovf;
      end else begin
         bus.wr_ack = inj_spur; bus.overflow = 1'b0;
      end
      inj_ovf = 1'b0; inj_drop = 1'b0; inj_spur = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 1'b0);
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'b1111, 1'b0);
      advance();
      drive(4'b1111, 1'b0);
      settle();
      if ({bus.grant, bus.wr_en, bus.req_ready, words_written, ovf_err, ack_err} !== 27'd0) begin
         failures++;
         $display("FAIL reset_hold got=%h want=0", {bus.grant, bus.wr_en, bus.req_ready, words_written, ovf_err, ack_err});
      end
      checks++;
      advance();
      rst = 1'b0;
      drive(4'b1111, 1'b0);
      settle();
      if (act_vec !== exp_vec) begin failures++; $display("FAIL reset_arb got=%h want=%h", act_vec, exp_vec); end
      checks++;
      advance();
      drive(4'b1111, 1'b0);
      settle();
      if (bus.grant !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b want=0001", bus.grant); end
      checks++;
      advance();
   endtask

   task automatic test_single_producer();
      logic [9:0] tr = '0;
      int sent = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive((sent < 6) ? 4'b0001 : 4'b0000, 1'b0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL single c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         tr = {tr[8:0], bus.wr_en};
         if (c == 9) begin
            if (words_written !== 16'd6) begin failures++; $display("FAIL single_words got=%0d want=6", words_written); end
            checks++;
         end
         if (exp_we) sent++;
         advance();
      end
      if (tr !== 10'b0111101100) begin failures++; $display("FAIL single_trace got=%b want=0111101100", tr); end
      checks++;
   endtask

   task automatic test_all_valid();
      logic [3:0] gq[$];
      logic [3:0] prev = 4'b0000;
      logic [3:0] got;
      logic [3:0] want;
      int nw = 0;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         drive(4'b1111, 1'b0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL all_valid c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         if (bus.grant != 4'b0000 && prev == 4'b0000) gq.push_back(bus.grant);
         prev = bus.grant;
         if (c < 20 && bus.wr_en === 1'b1) nw++;
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         got  = (i < gq.size()) ? gq[i] : 4'bxxxx;
         want = 4'b0001 << (i % 4);
         if (got !== want) begin failures++; $display("FAIL grant_seq%0d got=%b want=%b", i, got, want); end
         checks++;
      end
      if (nw !== 16) begin failures++; $display("FAIL all_writes got=%0d want=16", nw); end
      checks++;
   endtask

   task automatic test_full_stall();
      logic [8:0] tr = '0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         drive(4'b0100, (c >= 3 && c <= 5));
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL stall c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         tr = {tr[7:0], bus.wr_en};
         if (c >= 3 && c <= 5) begin
            if ({bus.grant, bus.wr_en, bus.req_ready} !== 9'b0100_0_0000) begin
               failures++; $display("FAIL stall_hold c%0d got=%b want=010000000", c, {bus.grant, bus.wr_en, bus.req_ready});
            end
            checks++;
         end
         advance();
      end
      if (tr !== 9'b011000110) begin failures++; $display("FAIL stall_trace got=%b want=011000110", tr); end
      checks++;
      for (int c = 0; c < 3; c++) begin
         drive(4'b0000, 1'b0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL stall_tail c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         advance();
      end
   endtask

   task automatic test_drop_valid();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive((c < 3) ? 4'b1010 : 4'b1000, 1'b0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL drop c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         if (c == 3) begin
            if ({bus.grant, bus.wr_en} !== 5'b0010_0) begin failures++; $display("FAIL drop_exit got=%b want=00100", {bus.grant, bus.wr_en}); end
            checks++;
         end
         if (c == 5) begin
            if (bus.grant !== 4'b1000) begin failures++; $display("FAIL drop_next got=%b want=1000", bus.grant); end
            checks++;
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         rst = (c == 17);
         drive(4'b1111, 1'b0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL midrst c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         if (c == 16) begin
            if (bus.grant !== 4'b1000) begin failures++; $display("FAIL midrst_owner got=%b want=1000", bus.grant); end
            checks++;
         end
         if (c == 18) begin
            if ({bus.grant, bus.wr_en, bus.req_ready, words_written, ovf_err, ack_err} !== 27'd0) begin
               failures++; $display("FAIL midrst_clear got=%h want=0", {bus.grant, bus.wr_en, bus.req_ready, words_written, ovf_err, ack_err});
            end
            checks++;
         end
         if (c == 19) begin
            if (bus.grant !== 4'b0001) begin failures++; $display("FAIL midrst_regrant got=%b want=0001", bus.grant); end
            checks++;
         end
         advance();
      end
      rst = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int c = 0; c < 25; c++) begin
         drive((c < 4) ? 4'b0001 : 4'b1111, 1'b0);
         inj_ovf = (c == 2);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL ovf c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         if (c == 4 || c == 24) begin
            if ({ovf_err, ack_err} !== 2'b10) begin failures++; $display("FAIL ovf_sticky c%0d got=%b want=10", c, {ovf_err, ack_err}); end
            checks++;
         end
         advance();
      end
   endtask

   task automatic test_spurious_ack();
      for (int c = 0; c < 12; c++) begin
         drive(4'b0000, 1'b0);
         inj_spur = (c == 8);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL spur c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         if (c == 8) begin
            if (ack_err !== 1'b0) begin failures++; $display("FAIL spur_before got=%b want=0", ack_err); end
            checks++;
         end
         if (c == 10) begin
            if ({ovf_err, ack_err} !== 2'b11) begin failures++; $display("FAIL spur_after got=%b want=11", {ovf_err, ack_err}); end
            checks++;
         end
         advance();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst = ((c % 200) == 199);
         drive(4'($urandom()) | 4'($urandom()), ($urandom_range(4) == 0));
         inj_ovf  = ($urandom_range(49) == 0);
         inj_drop = ($urandom_range(49) == 0);
         inj_spur = ($urandom_range(29) == 0);
         settle();
         if (act_vec !== exp_vec) begin failures++; $display("FAIL random c%0d got=%h want=%h", c, act_vec, exp_vec); end
         checks++;
         advance();
      end
      rst = 1'b0;
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   // Scenario sequence.
   initial begin
      rst = 1'b1;
      m_owner = -1; m_last = N - 1; m_left = 0;
      m_words = 16'd0; m_ovf = 1'b0; m_ack = 1'b0; m_wd = 1'b0;
      inj_ovf = 1'b0; inj_drop = 1'b0; inj_spur = 1'b0;
      bus.req_valid = '0; bus.req_data = '0; bus.full = 1'b0;
      bus.wr_ack = 1'b0; bus.overflow = 1'b0;
      test_reset();
      test_single_producer();
      test_all_valid();
      test_full_stall();
      test_drop_valid();
      test_reset_mid_burst();
      test_overflow();
      test_spurious_ack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
